// File: rtl/jpeg_fb_pkg.sv
// Shared types and helpers for the JPEG framebuffer writer.
package jpeg_fb_pkg;

  localparam logic [3:0] STRB_LO  = 4'b0011;
  localparam logic [3:0] STRB_HI  = 4'b1100;
  localparam logic [3:0] STRB_ALL = 4'b1111;

  // Action taken by the pairing logic in a given cycle.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLIP,
    ACT_LOAD,
    ACT_MERGE,
    ACT_LONE,
    ACT_FLUSH
  } act_e;

  function automatic logic [15:0] rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/jpeg_fb_writer_if.sv
// Pixel-in and framebuffer-write handshake interfaces.
interface jpeg_fb_pix_if;
  logic        valid;
  logic        accept;
  logic [15:0] width;
  logic [15:0] height;
  logic [15:0] x;
  logic [15:0] y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  modport master (output valid, width, height, x, y, r, g, b, input accept);
  modport slave  (input valid, width, height, x, y, r, g, b, output accept);
endinterface

interface jpeg_fb_wr_if #(parameter int ADDR_W = 32);
  logic              valid;
  logic              accept;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic [3:0]        strb;

  modport master (output valid, addr, data, strb, input accept);
  modport slave  (input valid, addr, data, strb, output accept);
endinterface

// File: rtl/jpeg_fb_addr.sv
// Stage-A byte address register: base + y*stride + x*2, stride 0 selects width*2.
module jpeg_fb_addr #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       stride,
  input  logic [15:0]       width,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  output logic [ADDR_W-1:0] addr
);

  logic [15:0] stride_eff;
  logic [31:0] row_off;
  logic [16:0] col_off;

  // Effective stride and the two address offsets.
  always_comb begin
    stride_eff = (stride == 16'd0) ? (width << 1) : stride;
    row_off    = 32'(y) * 32'(stride_eff);
    col_off    = {x, 1'b0};
  end

  // Address is latched together with the rest of the stage-A capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr <= '0;
    else if (en) addr <= base + ADDR_W'(row_off) + ADDR_W'(col_off);
  end

endmodule

// File: rtl/jpeg_fb_writer.sv
// JPEG decoder pixel stream to RGB565 framebuffer word writes with pair merging.
module jpeg_fb_writer
  import jpeg_fb_pkg::*;
#(
  parameter int FLUSH_CYCLES = 16,
  parameter int ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [15:0]       cfg_stride_i,
  jpeg_fb_pix_if.slave      inport,
  jpeg_fb_wr_if.master      outport,
  output logic              frame_done_o,
  output logic              idle_o
);

  localparam int TW = $clog2(FLUSH_CYCLES + 1);

  logic              rdy;
  logic              a_full, a_in_range;
  logic [15:0]       a_rgb;
  logic [31:0]       a_target;
  logic [ADDR_W-1:0] a_addr, a_word;
  logic              h_full, h_last;
  logic [ADDR_W-1:0] h_addr;
  logic [15:0]       h_data;
  logic              o_valid, o_last;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_data;
  logic [3:0]        o_strb;
  logic [31:0]       cnt;
  logic [TW-1:0]     idle_cnt;
  logic              capture, o_free, a_adv, counted, reached;
  act_e              act;

  jpeg_fb_addr #(.ADDR_W(ADDR_W)) u_addr (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (capture),
    .base   (cfg_base_i),
    .stride (cfg_stride_i),
    .width  (inport.width),
    .x      (inport.x),
    .y      (inport.y),
    .addr   (a_addr)
  );

  // Pairing decision: a completed frame's held pixel goes out first, then the
  // stage-A pixel, then an idle flush. Loading H or dropping a clipped pixel
  // leaves the output register untouched, so those need no free output slot.
  always_comb begin
    act     = ACT_NONE;
    o_free  = !o_valid || outport.accept;
    a_word  = a_addr & ~ADDR_W'(3);
    if (h_full && h_last) begin
      if (o_free) act = ACT_FLUSH;
    end else if (a_full) begin
      if (!a_in_range) act = ACT_CLIP;
      else if (a_addr[1]) begin
        if (o_free) begin
          if (h_full && h_addr == a_word) act = ACT_MERGE;
          else if (h_full)                act = ACT_FLUSH;
          else                            act = ACT_LONE;
        end
      end else if (h_full) begin
        if (o_free) act = ACT_FLUSH;
      end else act = ACT_LOAD;
    end else if (h_full && idle_cnt == TW'(FLUSH_CYCLES) && o_free) begin
      act = ACT_FLUSH;
    end
    a_adv   = (act == ACT_CLIP) || (act == ACT_LOAD) || (act == ACT_MERGE) || (act == ACT_LONE);
    counted = (act == ACT_LOAD) || (act == ACT_MERGE) || (act == ACT_LONE);
    reached = counted && (cnt + 32'd1 == a_target);
    capture = inport.valid && inport.accept;
  end

  assign inport.accept   = rdy && (!a_full || a_adv);
  assign outport.valid   = o_valid;
  assign outport.addr    = o_addr;
  assign outport.data    = o_data;
  assign outport.strb    = o_strb;
  assign frame_done_o    = o_valid && outport.accept && o_last;
  assign idle_o          = !a_full && !h_full && !o_valid;

  // Stage A capture register and the idle-flush timer it restarts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_full     <= 1'b0;
      a_in_range <= 1'b0;
      a_rgb      <= '0;
      a_target   <= '0;
      idle_cnt   <= '0;
    end else begin
      if (capture) begin
        a_full     <= 1'b1;
        a_in_range <= (inport.x < inport.width) && (inport.y < inport.height);
        a_rgb      <= rgb565(inport.r, inport.g, inport.b);
        a_target   <= 32'(inport.width) * 32'(inport.height);
      end else if (a_adv) begin
        a_full <= 1'b0;
      end
      if (capture) idle_cnt <= '0;
      else if (idle_cnt != TW'(FLUSH_CYCLES)) idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // Hold register, output register and frame pixel counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdy     <= 1'b0;
      h_full  <= 1'b0;
      h_last  <= 1'b0;
      h_addr  <= '0;
      h_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_strb  <= '0;
      cnt     <= '0;
    end else begin
      rdy <= 1'b1;
      if (outport.accept) o_valid <= 1'b0;
      if (counted) cnt <= reached ? 32'd0 : cnt + 32'd1;
      case (act)
        ACT_LOAD: begin
          h_full <= 1'b1;
          h_last <= reached;
          h_addr <= a_word;
          h_data <= a_rgb;
        end
        ACT_MERGE: begin
          o_valid <= 1'b1;
          o_addr  <= h_addr;
          o_data  <= {a_rgb, h_data};
          o_strb  <= STRB_ALL;
          o_last  <= reached;
          h_full  <= 1'b0;
          h_last  <= 1'b0;
        end
        ACT_LONE: begin
          o_valid <= 1'b1;
          o_addr  <= a_word;
          o_data  <= {a_rgb, 16'h0000};
          o_strb  <= STRB_HI;
          o_last  <= reached;
        end
        ACT_FLUSH: begin
          o_valid <= 1'b1;
          o_addr  <= h_addr;
          o_data  <= {16'h0000, h_data};
          o_strb  <= STRB_LO;
          o_last  <= h_last;
          h_full  <= 1'b0;
          h_last  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// Directed scoreboard bench for jpeg_fb_writer.
module tb_jpeg_fb_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] base;
  logic [15:0] stride;
  logic        frame_done, idle;

  jpeg_fb_pix_if                 pix ();
  jpeg_fb_wr_if #(.ADDR_W(32))   wr ();

  jpeg_fb_writer #(.FLUSH_CYCLES(16), .ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .cfg_base_i   (base),
    .cfg_stride_i (stride),
    .inport       (pix),
    .outport      (wr),
    .frame_done_o (frame_done),
    .idle_o       (idle)
  );

  always #5 clk = ~clk;

  wr_t sb[$];
  int  n_cmp = 0, n_fail = 0, n_wr = 0, n_done = 0;
  bit  saw_stall = 0, prev_stall = 0;
  wr_t prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] c565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic logic [15:0] colx(input int i);
    return c565(8'(i * 32 + 7), 8'(i * 12 + 3), 8'(255 - i * 8));
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.addr = a; e.data = d; e.strb = s;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    int t = 0;
    pix.valid = 1'b1;
    pix.x = 16'(x); pix.y = 16'(y);
    pix.r = r; pix.g = g; pix.b = b;
    @(negedge clk);
    while (!pix.accept && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", 64'(t < 200), 64'd1);
    @(posedge clk);
    #1;
    pix.valid = 1'b0;
  endtask

  task automatic send_idx(input int x, input int y, input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 32 + 7); g = 8'(i * 12 + 3); b = 8'(255 - i * 8);
    send_pix(x, y, r, g, b);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((sb.size() != 0 || !idle) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_drain"}, 64'(t < 300), 64'd1);
  endtask

  // Output monitor: stability under backpressure, scoreboard pops, done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 64'(wr.valid), 64'd1);
        chk("hold_addr", 64'(wr.addr), 64'(prev.addr));
        chk("hold_data", 64'(wr.data), 64'(prev.data));
        chk("hold_strb", 64'(wr.strb), 64'(prev.strb));
      end
      prev_stall = wr.valid && !wr.accept;
      prev.addr = wr.addr; prev.data = wr.data; prev.strb = wr.strb;
      if (pix.valid && !pix.accept) saw_stall = 1'b1;
      if (wr.valid && wr.accept) begin
        n_wr++;
        chk("write_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", 64'(wr.addr), 64'(e.addr));
          chk("wr_data", 64'(wr.data), 64'(e.data));
          chk("wr_strb", 64'(wr.strb), 64'(e.strb));
        end
      end
      if (frame_done) n_done++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int w0;
    pix.valid = 1'b0; pix.width = 16'd0; pix.height = 16'd0;
    pix.x = 16'd0; pix.y = 16'd0; pix.r = 8'd0; pix.g = 8'd0; pix.b = 8'd0;
    wr.accept = 1'b1;
    base = 32'h1000; stride = 16'd0;
    #12;
    chk("rst_valid", 64'(wr.valid), 64'd0);
    chk("rst_addr", 64'(wr.addr), 64'd0);
    chk("rst_data", 64'(wr.data), 64'd0);
    chk("rst_strb", 64'(wr.strb), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_in_accept", 64'(pix.accept), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // adjacent pair
    pix.width = 16'd16; pix.height = 16'd8;
    push(32'h1000, 32'h001F_F800, 4'b1111);
    send_pix(0, 0, 8'hFF, 8'h00, 8'h00);
    send_pix(1, 0, 8'h00, 8'h00, 8'hFF);
    drain("pair");

    // lone odd pixel
    push(32'h1044, 32'h07E0_0000, 4'b1100);
    send_pix(3, 2, 8'h00, 8'hFF, 8'h00);
    drain("lone");

    // idle flush
    push(32'h1008, 32'h0000_FFFF, 4'b0011);
    send_pix(4, 0, 8'hFF, 8'hFF, 8'hFF);
    tick(8);
    chk("idle_flush_early", 64'(sb.size()), 64'd1);
    drain("idle_flush");

    // clipping and frame completion
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    sb.delete();
    n_done = 0; w0 = n_wr;
    pix.width = 16'd3; pix.height = 16'd1;
    push(32'h1000, {colx(1), colx(0)}, 4'b1111);
    push(32'h1004, {16'h0000, colx(2)}, 4'b0011);
    for (int x = 0; x < 8; x++) send_idx(x, 0, x);
    drain("clip");
    chk("clip_writes", 64'(n_wr - w0), 64'd2);
    chk("clip_done", 64'(n_done), 64'd1);

    // backpressure over an 8x8 block
    n_done = 0; w0 = n_wr; saw_stall = 1'b0;
    base = 32'h2000;
    pix.width = 16'd8; pix.height = 16'd8;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x += 2)
        push(32'h2000 + 32'(y * 16 + x * 2),
             {colx((y * 8 + x + 1) % 8), colx((y * 8 + x) % 8)}, 4'b1111);
    fork
      begin
        for (int y = 0; y < 8; y++)
          for (int x = 0; x < 8; x++) send_idx(x, y, (y * 8 + x) % 8);
      end
      begin
        tick(20);
        wr.accept = 1'b0;
        tick(20);
        wr.accept = 1'b1;
      end
    join
    drain("bp");
    chk("bp_writes", 64'(n_wr - w0), 64'd32);
    chk("bp_done", 64'(n_done), 64'd1);
    chk("bp_in_stall", 64'(saw_stall), 64'd1);

    // reset mid-frame with H and the output register occupied
    base = 32'h1000;
    pix.width = 16'd16; pix.height = 16'd8;
    wr.accept = 1'b0;
    send_idx(1, 0, 1);
    send_idx(2, 0, 2);
    tick(3);
    chk("pre_rst_valid", 64'(wr.valid), 64'd1);
    chk("pre_rst_idle", 64'(idle), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(wr.valid), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    chk("mid_rst_strb", 64'(wr.strb), 64'd0);
    tick(2);
    rst_n = 1'b1;
    wr.accept = 1'b1;
    sb.delete();
    tick(2);
    n_done = 0;
    pix.width = 16'd2; pix.height = 16'd1;
    push(32'h1000, {colx(1), colx(0)}, 4'b1111);
    send_idx(0, 0, 0);
    send_idx(1, 0, 1);
    drain("post_rst");
    chk("post_rst_done", 64'(n_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
